// File: rtl/snax_reqrsp_to_hwpe_if.sv
// HWPE TCDM port: a 32-bit req/gnt/r_valid memory channel.
// The master issues requests and receives read data. The slave grants them and returns
// exactly one r_valid for each grant, in grant order.
interface hwpe_stream_intf_tcdm;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;     // 1 = read, 0 = write
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (
    output req, add, wen, be, data,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, be, data,
    output gnt, r_data, r_valid
  );
endinterface

// File: rtl/snax_reqrsp_to_hwpe.sv
// Bridge from a SNAX/Snitch TCDM reqrsp port to an HWPE TCDM master port.
// A 64-bit double-word request is narrowed onto the 32-bit HWPE lane that addr[2] selects.
// A small FIFO records the lane of each in-flight transaction, so that every response is
// steered back into the correct half of the 64-bit response word.

package snax_reqrsp_to_hwpe_pkg;
  // Default 64-bit TCDM request/response types; integrators override the type parameters.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [63:0] data;
    logic [7:0]  strb;
  } tcdm_q_t;

  typedef struct packed {
    tcdm_q_t q;
    logic    q_valid;
  } tcdm_req_t;

  typedef struct packed {
    logic [63:0] data;
  } tcdm_p_t;

  typedef struct packed {
    logic    q_ready;
    tcdm_p_t p;
    logic    p_valid;
  } tcdm_rsp_t;
endpackage

module snax_reqrsp_to_hwpe #(
  parameter int unsigned DataWidth        = 64,
  parameter bit          AlignInputDouble = 1'b1,
  parameter int unsigned MaxOutstanding   = 2,
  parameter type         tcdm_req_t       = snax_reqrsp_to_hwpe_pkg::tcdm_req_t,
  parameter type         tcdm_rsp_t       = snax_reqrsp_to_hwpe_pkg::tcdm_rsp_t
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  tcdm_req_t                   tcdm_req_i,
  output tcdm_rsp_t                   tcdm_rsp_o,
  hwpe_stream_intf_tcdm.master        hwpe_tcdm_master,
  output logic                        err_o
);

  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxOutstanding - 1);
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(MaxOutstanding);

  // In-flight tracking state.
  logic [CntWidth-1:0]       count_q, count_d;
  logic [PtrWidth-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]       rd_ptr_q, rd_ptr_d;
  logic [MaxOutstanding-1:0] lane_mem_q, lane_mem_d;
  logic                      err_q, err_d;

  logic full;
  logic req_lane;
  logic head_lane;
  logic push;
  logic pop;
  logic rsp_spurious;

  // Full is a function of registered state only. As a result, gnt never loops back into req.
  // A response that pops in the same cycle does not free a slot until the next cycle.
  assign full      = (count_q == FullCnt);
  assign req_lane  = AlignInputDouble ? tcdm_req_i.q.addr[2] : 1'b0;
  assign head_lane = lane_mem_q[rd_ptr_q];

  assign push         = hwpe_tcdm_master.req & hwpe_tcdm_master.gnt;
  assign pop          = hwpe_tcdm_master.r_valid & (count_q != '0);
  assign rsp_spurious = hwpe_tcdm_master.r_valid & (count_q == '0);

  // Request path: narrow the double word onto the selected 32-bit lane.
  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    hwpe_tcdm_master.req  = tcdm_req_i.q_valid & ~full;
    hwpe_tcdm_master.add  = tcdm_req_i.q.addr;
    hwpe_tcdm_master.wen  = ~tcdm_req_i.q.write;
    hwpe_tcdm_master.be   = tcdm_req_i.q.strb[3:0];
    hwpe_tcdm_master.data = tcdm_req_i.q.data[31:0];
    if (req_lane) begin
      hwpe_tcdm_master.be   = tcdm_req_i.q.strb[DataWidth/8-1 -: 4];
      hwpe_tcdm_master.data = tcdm_req_i.q.data[DataWidth-1 -: 32];
    end
  end

  // Response path: place r_data in the lane recorded at the FIFO head and zero the other half.
  always_comb begin
    tcdm_rsp_o         = '0;
    tcdm_rsp_o.q_ready = hwpe_tcdm_master.gnt & ~full;
    tcdm_rsp_o.p_valid = pop;
    if (head_lane) begin
      tcdm_rsp_o.p.data[DataWidth-1 -: 32] = hwpe_tcdm_master.r_data;
    end else begin
      tcdm_rsp_o.p.data[31:0] = hwpe_tcdm_master.r_data;
    end
  end

  // Next-state of the lane FIFO, its occupancy and the sticky error flag.
  // NOTE: combinational blocks use blocking '=', clocked blocks use non-blocking '<=' only.
  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    lane_mem_d = lane_mem_q;
    err_d      = err_q | rsp_spurious;

    if (push) begin
      lane_mem_d[wr_ptr_q] = req_lane;
      wr_ptr_d             = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end

    // A push and a pop in the same cycle cancel out in the count.
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; an asynchronous reset discards every outstanding entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  // Lane storage.
  // NOTE: storage arrays are not reset. An entry is read only after a push has written it,
  // and count gates the read.
  always_ff @(posedge clk_i) begin
    lane_mem_q <= lane_mem_d;
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_snax_reqrsp_to_hwpe.sv
// Self-checking bench for snax_reqrsp_to_hwpe.
// A behavioural HWPE slave answers each grant after a programmable latency.
// Expected response words are queued when a request is granted and compared
// when the bridge raises p_valid.
module tb_snax_reqrsp_to_hwpe;
  import snax_reqrsp_to_hwpe_pkg::*;

  logic      clk_i  = 1'b0;
  logic      rst_ni = 1'b0;
  tcdm_req_t tcdm_req;
  tcdm_rsp_t tcdm_rsp;
  logic      err_o;

  hwpe_stream_intf_tcdm hwpe ();

  always #5 clk_i = ~clk_i;

  snax_reqrsp_to_hwpe #(
    .DataWidth       (64),
    .AlignInputDouble(1'b1),
    .MaxOutstanding  (2),
    .tcdm_req_t      (tcdm_req_t),
    .tcdm_rsp_t      (tcdm_rsp_t)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .tcdm_req_i      (tcdm_req),
    .tcdm_rsp_o      (tcdm_rsp),
    .hwpe_tcdm_master(hwpe.master),
    .err_o           (err_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // One request with the HWPE-side fields and the response word it must produce.
  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [31:0] rdata;   // what the slave returns for this transaction
    logic        wen;
    logic [3:0]  be;
    logic [31:0] hdata;
    logic [63:0] pdata;
  } vec_t;

  // ---------------- behavioural HWPE slave ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
  } slv_t;

  slv_t        slv_q[$];
  int          slv_lat   = 1;
  logic [31:0] slv_rdata = '0;
  int          spur_cnt  = 0;
  int          cyc       = 0;

  always begin
    bit          fire;
    bit          popd;
    bit          spur_on;
    int          spur_seen;
    logic [31:0] cap;
    @(negedge clk_i);
    fire = rst_ni && hwpe.req && hwpe.gnt;
    popd = (hwpe.r_valid === 1'b1) && !spur_on;
    cap  = slv_rdata;
    @(posedge clk_i);
    cyc++;
    #1;
    if (popd && slv_q.size() > 0) void'(slv_q.pop_front());
    if (fire) slv_q.push_back('{due: cyc - 1 + slv_lat, data: cap});
    spur_on   = (spur_cnt != spur_seen);
    spur_seen = spur_cnt;
    if (spur_on) begin
      hwpe.r_valid = 1'b1;
      hwpe.r_data  = 32'h0BAD_0BAD;
    end else if (slv_q.size() > 0 && slv_q[0].due <= cyc) begin
      hwpe.r_valid = 1'b1;
      hwpe.r_data  = slv_q[0].data;
    end else begin
      hwpe.r_valid = 1'b0;
      hwpe.r_data  = '0;
    end
  end

  // ---------------- response scoreboard ----------------
  logic [63:0] exp_q[$];
  bit          err_exp = 1'b0;

  always begin
    @(negedge clk_i);
    if (!rst_ni) begin
      exp_q.delete();
      err_exp = 1'b0;
    end else begin
      check("err_o", err_o, err_exp);
      if (hwpe.r_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("p_valid on spurious r_valid", tcdm_rsp.p_valid, 0);
          err_exp = 1'b1;
        end else begin
          check("p_valid on r_valid", tcdm_rsp.p_valid, 1);
          check("p_data", tcdm_rsp.p.data, exp_q.pop_front());
        end
      end else begin
        check("p_valid idle", tcdm_rsp.p_valid, 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic vec_t rd(input logic [31:0] a, input logic [31:0] r, input logic [63:0] p);
    vec_t v;
    v.addr  = a;     v.write = 1'b0;  v.data  = '0;  v.strb  = 8'hFF;
    v.rdata = r;     v.wen   = 1'b1;  v.be    = 4'hF; v.hdata = '0;
    v.pdata = p;
    return v;
  endfunction

  // Drive one request, wait (bounded) for the grant, check the HWPE fields, queue the response.
  task automatic send(input vec_t v, input string name, output int gcyc);
    bit done = 1'b0;
    gcyc = -1;
    tcdm_req.q_valid = 1'b1;
    tcdm_req.q.addr  = v.addr;
    tcdm_req.q.write = v.write;
    tcdm_req.q.data  = v.data;
    tcdm_req.q.strb  = v.strb;
    slv_rdata        = v.rdata;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk_i);
      if (tcdm_rsp.q_ready === 1'b1) begin
        done = 1'b1;
        gcyc = cyc;
        check({name, " req"},  hwpe.req,  1);
        check({name, " add"},  hwpe.add,  v.addr);
        check({name, " wen"},  hwpe.wen,  v.wen);
        check({name, " be"},   hwpe.be,   v.be);
        check({name, " data"}, hwpe.data, v.hdata);
      end
      @(posedge clk_i);
      #1;
    end
    check({name, " granted"}, done, 1);
    if (done) exp_q.push_back(v.pdata);
  endtask

  task automatic idle(input string name);
    tcdm_req.q_valid = 1'b0;
    @(negedge clk_i);
    check({name, " req low when idle"}, hwpe.req, 0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input string name);
    bit empty = 1'b0;
    for (int i = 0; i < 40 && !empty; i++) begin
      @(negedge clk_i);
      empty = (exp_q.size() == 0) && (slv_q.size() == 0);
      @(posedge clk_i);
      #1;
    end
    check({name, " drained"}, empty, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  vec_t vecs[7];
  int   g[4];
  int   gprev;

  initial begin
    vecs[0] = '{32'h0000_0104, 1'b0, 64'h0, 8'hFF, 32'hDEAD_BEEF,
                1'b1, 4'hF, 32'h0, 64'hDEAD_BEEF_0000_0000};
    vecs[1] = '{32'h0000_0100, 1'b0, 64'h0, 8'hFF, 32'hDEAD_BEEF,
                1'b1, 4'hF, 32'h0, 64'h0000_0000_DEAD_BEEF};
    vecs[2] = '{32'h0000_010C, 1'b1, 64'h1122_3344_5566_7788, 8'hF0, 32'hCAFE_F00D,
                1'b0, 4'hF, 32'h1122_3344, 64'hCAFE_F00D_0000_0000};
    vecs[3] = '{32'h0000_0208, 1'b1, 64'hAABB_CCDD_EEFF_0011, 8'h0C, 32'h0,
                1'b0, 4'hC, 32'hEEFF_0011, 64'h0};
    vecs[4] = '{32'hFFFF_FFFC, 1'b0, 64'h0, 8'h30, 32'h1234_5678,
                1'b1, 4'h3, 32'h0, 64'h1234_5678_0000_0000};
    vecs[5] = '{32'h0000_0050, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h81, 32'h5A5A_5A5A,
                1'b0, 4'h1, 32'h89AB_CDEF, 64'h0000_0000_5A5A_5A5A};
    vecs[6] = '{32'h0000_0054, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h81, 32'hA5A5_A5A5,
                1'b0, 4'h8, 32'h0123_4567, 64'hA5A5_A5A5_0000_0000};

    // Reset: request path follows the inputs, no response, no error.
    tcdm_req         = '0;
    tcdm_req.q_valid = 1'b1;
    hwpe.gnt         = 1'b1;
    @(negedge clk_i);
    check("reset req follows q_valid", hwpe.req, 1);
    check("reset q_ready follows gnt", tcdm_rsp.q_ready, 1);
    check("reset p_valid", tcdm_rsp.p_valid, 0);
    check("reset err_o", err_o, 0);
    @(posedge clk_i);
    #1;
    hwpe.gnt = 1'b0;
    @(negedge clk_i);
    check("reset q_ready low without gnt", tcdm_rsp.q_ready, 0);
    check("reset req independent of gnt", hwpe.req, 1);
    @(posedge clk_i);
    #1;
    tcdm_req.q_valid = 1'b0;
    hwpe.gnt         = 1'b1;
    rst_ni           = 1'b1;
    idle("post reset");

    // Table: back-to-back transfers at slave latency 1, one grant per cycle.
    gprev = 0;
    for (int i = 0; i < 7; i++) begin
      send(vecs[i], $sformatf("vec%0d", i), g[0]);
      if (i > 0) check($sformatf("vec%0d grant cycle", i), g[0], gprev + 1);
      gprev = g[0];
    end
    idle("table");
    drain("table");

    // Slave back-pressure: req stays up without gnt, q_ready follows gnt.
    tcdm_req.q_valid = 1'b1;
    hwpe.gnt         = 1'b0;
    @(negedge clk_i);
    check("no gnt: req", hwpe.req, 1);
    check("no gnt: q_ready", tcdm_rsp.q_ready, 0);
    @(posedge clk_i);
    #1;
    hwpe.gnt = 1'b1;
    idle("backpressure");

    // Full: slave latency 3, four reads to alternating lanes.
    slv_lat = 3;
    send(rd(32'h200, 32'hA000_0000, 64'h0000_0000_A000_0000), "full0", g[0]);
    send(rd(32'h204, 32'hA111_1111, 64'hA111_1111_0000_0000), "full1", g[1]);
    send(rd(32'h208, 32'hA222_2222, 64'h0000_0000_A222_2222), "full2", g[2]);
    send(rd(32'h20C, 32'hA333_3333, 64'hA333_3333_0000_0000), "full3", g[3]);
    idle("full");
    check("full: second grant", g[1] - g[0], 1);
    check("full: third grant after first pop", g[2] - g[0], 4);
    check("full: fourth grant", g[3] - g[0], 5);
    drain("full");

    // Simultaneous push and pop at count 1; each response uses its own lane.
    slv_lat = 1;
    send(rd(32'h300, 32'h1111_1111, 64'h0000_0000_1111_1111), "pp0", g[0]);
    send(rd(32'h304, 32'h2222_2222, 64'h2222_2222_0000_0000), "pp1", g[1]);
    send(rd(32'h308, 32'h3333_3333, 64'h0000_0000_3333_3333), "pp2", g[2]);
    idle("pushpop");
    check("pushpop: grant 1", g[1] - g[0], 1);
    check("pushpop: grant 2", g[2] - g[1], 1);
    drain("pushpop");

    // Spurious r_valid with an empty FIFO: dropped, sticky error.
    @(negedge clk_i);
    spur_cnt++;
    @(posedge clk_i);
    #1;
    repeat (2) @(posedge clk_i);
    #1;
    check("err set by spurious r_valid", err_o, 1);
    send(rd(32'h400, 32'h7777_0000, 64'h0000_0000_7777_0000), "after err", g[0]);
    idle("after err");
    drain("after err");
    check("err stays set", err_o, 1);

    // Reset with two reads outstanding; late responses raise err and are dropped.
    slv_lat = 4;
    send(rd(32'h500, 32'h5000_0001, 64'h0000_0000_5000_0001), "rst0", g[0]);
    send(rd(32'h504, 32'h5000_0002, 64'h5000_0002_0000_0000), "rst1", g[1]);
    tcdm_req.q_valid = 1'b0;
    rst_ni           = 1'b0;
    @(negedge clk_i);
    check("mid reset err_o cleared", err_o, 0);
    check("mid reset p_valid", tcdm_rsp.p_valid, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    drain("late rsp");
    check("err after late response", err_o, 1);
    slv_lat = 1;
    send(rd(32'h604, 32'h6666_6666, 64'h6666_6666_0000_0000), "recovery", g[0]);
    idle("recovery");
    drain("recovery");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
